tick_paced_updown_counter: RTL and testbench
============================================

Name: tick_paced_updown_counter

Overview:
- Single-clock block that divides the system clock down to a slow step rate, nominally 1 Hz, using an internal prescaler.
- On each step it advances an 8-bit up/down counter that wraps at a programmable limit.
- Feeds LED-sequencing logic, which advances one position each time the count wraps.
- Replaces a derived slow clock with a clock-enable, so everything runs on clk.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- TICK_HZ, 1, step rate. DIV = CLK_FREQ_HZ/TICK_HZ (integer division); DIV must be >= 2, else elaboration error.
- WIDTH, 8, counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears prescaler and counter.
- dir  in  1  1 = count up, 0 = count down.
- pause  in  1  1 = hold count; prescaler keeps running.
- max_num  in  WIDTH  inclusive wrap limit.
- count  out  WIDTH  current count, registered.
- tick  out  1  step strobe, high for exactly one clk cycle every DIV cycles.
- wrap  out  1  registered one-cycle pulse, set on the step edge where count wraps.

Behaviour:
- Reset (async assert, synchronous-safe deassert): prescaler=0, count=0, wrap=0, tick=0.
- Prescaler:
  - free-runs 0..DIV-1, returns to 0 after DIV-1; ignores pause/dir/max_num.
  - tick = (prescaler == DIV-1), decoded from a register, glitch-free.
  - First tick is high in cycle DIV-1 after reset release (cycles counted from 0).
- Step edge: rising clk edge where tick=1. dir, pause and max_num are sampled only at step edges; changes between steps have no effect until the next step.
- At a step edge, with pause=0:
  - up, count < max_num: count+1.
  - up, count >= max_num: count = 0, wrap=1.
  - down, count > 0 and count <= max_num: count-1.
  - down, count == 0: count = max_num, wrap=1.
  - down, count > max_num (limit lowered mid-run): count = max_num, wrap=1.
- At a step edge with pause=1: count holds, wrap=0.
- wrap is 0 on every non-step edge, so it is at most one cycle wide.
- max_num = 0: count stays 0 and wrap pulses on every unpaused step in either direction.
- Up period is max_num+1 steps: 0,1,..,max_num,0. Down: max_num,..,0,max_num.
- Direction reversal at a step takes effect that step, with no extra wait state. Example: count 3, dir 1->0 gives 2 next step.
- Arithmetic: unsigned WIDTH-bit. No overflow is possible because wrap is explicit. max_num = 2^WIDTH-1 behaves like a natural modulo counter.
- Reset mid-operation: immediate clear. Counting resumes from 0 and the prescaler phase restarts.

Test Plan:
- CLK_FREQ_HZ=8, TICK_HZ=1 (DIV=8), rst pulse -> count=0, tick=0; tick high in cycles 7, 15, 23..., never two consecutive cycles.
- DIV=8, dir=1, pause=0, max_num=3, 40 cycles -> count 0,1,2,3,0,1 changing only after tick edges; wrap high exactly one cycle after the 3->0 step.
- Same, dir=0 from reset -> count 3,2,1,0,3; wrap after the 0->3 step.
- pause=1 across three ticks with count=2 -> count stays 2, wrap 0, tick still pulses every 8 cycles; pause=0 -> next step gives 3.
- count=5, max_num lowered to 2: up -> next step 0 with wrap; repeat with down -> next step 2 with wrap.
- max_num=0 -> count constant 0, wrap each step. Async rst asserted mid-period (no clk edge) -> count, prescaler, tick and wrap clear immediately.

Source files
------------

// File: rtl/tick_paced_updown_counter.sv
// tick_paced_updown_counter: prescaler-generated clock enable stepping a wrapping up/down counter.
module tick_paced_updown_counter #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ     = 1,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             pause,
  input  logic [WIDTH-1:0] max_num,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW = DIV > 2 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  if (DIV < 2) begin : g_div_chk
    $error("tick_paced_updown_counter: CLK_FREQ_HZ/TICK_HZ must be >= 2");
  end
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic             up_wrap, dn_wrap;
  always_comb begin
    presc_d = presc_q == LAST ? '0 : presc_q + 1'b1;
    // tick is registered one cycle ahead so it is high exactly while presc_q == LAST
    tick_d  = presc_d == LAST;
    up_wrap = count_q >= max_num;
    dn_wrap = count_q == '0 || count_q > max_num;
    count_d = (!tick_q || pause) ? count_q :
              dir ? (up_wrap ? '0 : count_q + 1'b1) :
                    (dn_wrap ? max_num : count_q - 1'b1);
    wrap_d  = tick_q && !pause && (dir ? up_wrap : dn_wrap);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
endmodule

// File: tb/tb_tick_paced_updown_counter.sv
// tb_tick_paced_updown_counter: directed scoreboard bench with DIV=8; expected step results are queued then checked after each tick edge.
module tb_tick_paced_updown_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dir = 1'b1;
  logic       pause = 1'b0;
  logic [7:0] max_num = 8'd3;
  logic [7:0] count;
  logic       tick, wrap;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0] c;
    logic       w;
  } exp_t;
  exp_t q[$];

  tick_paced_updown_counter #(.CLK_FREQ_HZ(8), .TICK_HZ(1), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .dir(dir), .pause(pause), .max_num(max_num),
    .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic w);
    exp_t e;
    e.c = c;
    e.w = w;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wrap", 32'(wrap), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick_timeout"}, 32'(n < 20), 1);
  endtask

  task automatic step(input string tag);
    exp_t e;
    wait_tick(tag);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "_count"}, 32'(count), 32'(e.c));
    chk({tag, "_wrap"}, 32'(wrap), 32'(e.w));
    chk({tag, "_tick_single"}, 32'(tick), 0);
    @(posedge clk);
    #1;
    chk({tag, "_wrap_1cyc"}, 32'(wrap), 0);
    chk({tag, "_count_hold"}, 32'(count), 32'(e.c));
  endtask

  initial begin
    exp_t e;
    int n;
    #1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      chk("tick_phase", 32'(tick), 32'(i % 8 == 7));
      chk("up_count_between", 32'(count), 32'(i / 8));
      chk("up_wrap_idle", 32'(wrap), 0);
      @(negedge clk);
    end
    push(8'd0, 1'b1); step("up_wrap");
    push(8'd1, 1'b0); step("up_after_wrap");

    dir = 1'b0;
    do_reset();
    push(8'd3, 1'b1); step("dn_0to3");
    push(8'd2, 1'b0); step("dn_2");
    push(8'd1, 1'b0); step("dn_1");
    push(8'd0, 1'b0); step("dn_0");
    push(8'd3, 1'b1); step("dn_rewrap");

    dir = 1'b1;
    max_num = 8'd7;
    do_reset();
    push(8'd1, 1'b0); step("pre_pause1");
    push(8'd2, 1'b0); step("pre_pause2");
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(8'd2, 1'b0); step("paused");
    end
    pause = 1'b0;
    push(8'd3, 1'b0); step("resume");
    dir = 1'b0;
    push(8'd2, 1'b0); step("reverse");

    dir = 1'b1;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), 1'b0); step("climb_up");
    end
    max_num = 8'd2;
    push(8'd0, 1'b1); step("lowered_up");

    max_num = 8'd7;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), 1'b0); step("climb_dn");
    end
    max_num = 8'd2;
    dir = 1'b0;
    push(8'd2, 1'b1); step("lowered_dn");

    max_num = 8'd0;
    dir = 1'b1;
    do_reset();
    push(8'd0, 1'b1); step("max0_up_a");
    push(8'd0, 1'b1); step("max0_up_b");
    dir = 1'b0;
    push(8'd0, 1'b1); step("max0_dn");

    push(8'd0, 1'b1);
    wait_tick("async");
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("async_pre_wrap", 32'(wrap), 32'(e.w));
    #2;
    rst = 1'b1;
    #1;
    chk("async_wrap_clr", 32'(wrap), 0);
    chk("async_count_clr", 32'(count), 0);
    chk("async_tick_clr", 32'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("async_phase_restart", 32'(n), 7);
    rst = 1'b1;
    #1;
    chk("async_tick_high_clr", 32'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
